tla_gate_seq: RTL and testbench

Gate-window sequencer in the 200 MHz acquisition domain, directly downstream of the 125→200 MHz control crossing. It consumes the crossed `com_open`/`com_close` pulses and the quasi-static capture/compare settings. It then drives a burst of gate windows of programmed width and count. Window index, busy and done status return to the control domain through the crossing's status path.

---
 rtl/tla_pkg.sv | 20 ++
 rtl/tla_gate_cnt.sv | 29 ++
 rtl/tla_gate_seq.sv | 147 ++++++++++++++
 tb/tb_tla_gate_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tla_pkg.sv
// Shared types and width constants for the gate-window sequencer.
package tla_pkg;

    localparam int unsigned TOP0_0 = 3;
    localparam int unsigned LDD0_0 = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GATE,
        ST_GAP,
        ST_DONE
    } tla_state_e;

    typedef struct packed {
        logic              mode;
        logic [TOP0_0-1:0] wdis;
        logic [LDD0_0-1:0] plus;
    } tla_set_t;

endpackage

// File: rtl/tla_gate_cnt.sv
// Loadable down-counter timing gate and gap phases; zero flags phase end.
module tla_gate_cnt
    import tla_pkg::*;
#(
    parameter int unsigned W = LDD0_0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_dec,
    input  logic [W-1:0] i_val,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tla_gate_seq.sv
// Gate-window sequencer: bursts of N gate windows of L cycles separated by
// L-cycle gaps, with close-abort and done/abort status pulses.
module tla_gate_seq #(
    parameter int unsigned TOP0_0 = tla_pkg::TOP0_0,
    parameter int unsigned LDD0_0 = tla_pkg::LDD0_0
) (
    input  logic              Ga_clk200,
    input  logic              Gc_rst,
    input  logic              Ga_cap_mode,
    input  logic [TOP0_0-1:0] Ga_cap_wdis,
    input  logic [LDD0_0-1:0] Ga_cap_plus,
    input  logic [TOP0_0-1:0] Ga_com_wdis,
    input  logic [LDD0_0-1:0] Ga_com_plus,
    input  logic              Ga_com_open,
    input  logic              Ga_com_close,
    output logic              Ga_gate,
    output logic              Ga_busy,
    output logic              Ga_done,
    output logic              Ga_abort,
    output logic [TOP0_0-1:0] Ga_wdis
);

    import tla_pkg::tla_state_e;
    import tla_pkg::tla_set_t;
    import tla_pkg::ST_IDLE;
    import tla_pkg::ST_GATE;
    import tla_pkg::ST_GAP;
    import tla_pkg::ST_DONE;

    tla_state_e        r_state;
    tla_state_e        w_next;
    tla_set_t          r_set;
    tla_set_t          w_in_set;
    logic [TOP0_0-1:0] r_idx;
    logic [TOP0_0-1:0] w_idx_next;
    logic              w_accept;
    logic              w_load;
    logic              w_dec;
    logic [LDD0_0-1:0] w_load_val;
    logic              w_zero;
    logic              r_gate;
    logic              r_busy;
    logic              r_done;
    logic              r_abort;

    assign w_in_set = Ga_cap_mode ? {1'b1, Ga_cap_wdis, Ga_cap_plus}
                                  : {1'b0, Ga_com_wdis, Ga_com_plus};
    // Close in IDLE drops a simultaneous open.
    assign w_accept = (r_state == ST_IDLE) && Ga_com_open && !Ga_com_close;

    tla_gate_cnt #(
        .W (LDD0_0)
    ) u_cnt (
        .i_clk  (Ga_clk200),
        .i_rst  (Gc_rst),
        .i_load (w_load),
        .i_dec  (w_dec),
        .i_val  (w_load_val),
        .o_zero (w_zero)
    );

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_dec      = 1'b0;
        w_load_val = r_set.plus - 1'b1;
        w_idx_next = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_in_set.plus == '0) begin
                        w_next = ST_DONE;
                    end else begin
                        w_load     = 1'b1;
                        w_load_val = w_in_set.plus - 1'b1;
                        w_idx_next = '0;
                        w_next     = ST_GATE;
                    end
                end
            end
            ST_GATE: begin
                if (Ga_com_close) begin
                    w_next = ST_IDLE;
                end else if (w_zero) begin
                    if (r_idx == r_set.wdis) begin
                        w_next = ST_DONE;
                    end else begin
                        w_load = 1'b1;
                        w_next = ST_GAP;
                    end
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_GAP: begin
                if (Ga_com_close) begin
                    w_next = ST_IDLE;
                end else if (w_zero) begin
                    w_idx_next = r_idx + 1'b1;
                    w_load     = 1'b1;
                    w_next     = ST_GATE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Ga_clk200 or posedge Gc_rst) begin
        if (Gc_rst) begin
            r_state <= ST_IDLE;
            r_set   <= '0;
            r_idx   <= '0;
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_idx_next;
            if (w_accept) begin
                r_set <= w_in_set;
            end
            // Outputs registered from next state so they align with r_state.
            r_gate  <= (w_next == ST_GATE);
            r_busy  <= (w_next != ST_IDLE);
            r_done  <= (w_next == ST_DONE);
            r_abort <= Ga_com_close && (r_state != ST_IDLE);
        end
    end

    a_set_frozen : assert property (@(posedge Ga_clk200) disable iff (Gc_rst)
        (r_state != ST_IDLE) |=> $stable(r_set));

    assign Ga_gate  = r_gate;
    assign Ga_busy  = r_busy;
    assign Ga_done  = r_done;
    assign Ga_abort = r_abort;
    assign Ga_wdis  = r_idx;

endmodule

// File: tb/tb_tla_gate_seq.sv
// Self-checking bench for tla_gate_seq: directed scenarios plus random
// traffic against a timeline model of the burst (window = f(elapsed cycles)).
module tb_tla_gate_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_mode = 1'b0;
    logic [2:0]  cap_wdis = '0;
    logic [31:0] cap_plus = '0;
    logic [2:0]  com_wdis = '0;
    logic [31:0] com_plus = '0;
    logic        com_open = 1'b0;
    logic        com_close = 1'b0;
    logic        gate, busy, done, abort_o;
    logic [2:0]  wdis;

    int n_checks = 0;
    int n_errors = 0;

    // Model: elapsed cycle t since the accepted open (t=1 is first busy cycle).
    bit              m_act = 1'b0;
    bit              m_ab  = 1'b0;
    longint unsigned m_t   = 0;
    longint unsigned m_L   = 0;
    longint unsigned m_N   = 1;
    longint unsigned m_dt  = 0;
    longint unsigned m_hold = 0;

    always #5 clk = ~clk;

    tla_gate_seq #(
        .TOP0_0 (3),
        .LDD0_0 (32)
    ) dut (
        .Ga_clk200    (clk),
        .Gc_rst       (rst),
        .Ga_cap_mode  (cap_mode),
        .Ga_cap_wdis  (cap_wdis),
        .Ga_cap_plus  (cap_plus),
        .Ga_com_wdis  (com_wdis),
        .Ga_com_plus  (com_plus),
        .Ga_com_open  (com_open),
        .Ga_com_close (com_close),
        .Ga_gate      (gate),
        .Ga_busy      (busy),
        .Ga_done      (done),
        .Ga_abort     (abort_o),
        .Ga_wdis      (wdis)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint unsigned idx_at(longint unsigned t);
        longint unsigned w;
        if (m_L == 0) return m_hold;
        w = (t - 1) / (2 * m_L);
        return (w > m_N - 1) ? m_N - 1 : w;
    endfunction

    task automatic model_step(input bit o, input bit c);
        if (m_act) begin
            m_ab = 1'b0;
            if (c) begin
                m_hold = idx_at(m_t);
                m_act  = 1'b0;
                m_ab   = 1'b1;
            end else if (m_t == m_dt) begin
                m_hold = idx_at(m_t);
                m_act  = 1'b0;
            end else begin
                m_t++;
            end
        end else begin
            m_ab = 1'b0;
            if (o && !c) begin
                m_L   = cap_mode ? longint'(cap_plus) : longint'(com_plus);
                m_N   = (cap_mode ? longint'(cap_wdis) : longint'(com_wdis)) + 1;
                m_dt  = (m_L == 0) ? 1 : m_L * (2 * m_N - 1) + 1;
                m_t   = 1;
                m_act = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        bit e_gate;
        e_gate = m_act && (m_L != 0) && (m_t < m_dt) && (((m_t - 1) % (2 * m_L)) < m_L);
        chk("gate",  64'(gate),    64'(e_gate));
        chk("busy",  64'(busy),    64'(m_act));
        chk("done",  64'(done),    64'(m_act && (m_t == m_dt)));
        chk("abort", 64'(abort_o), 64'(m_ab));
        chk("wdis",  64'(wdis),    m_act ? idx_at(m_t) : m_hold);
    endtask

    task automatic cyc(input bit o, input bit c);
        com_open  = o;
        com_close = c;
        @(posedge clk);
        model_step(o, c);
        @(negedge clk);
        com_open  = 1'b0;
        com_close = 1'b0;
        compare_all();
    endtask

    task automatic set_cfg(input bit md, input logic [2:0] cw, input logic [31:0] cp,
                           input logic [2:0] ow, input logic [31:0] op);
        cap_mode = md;
        cap_wdis = cw;
        cap_plus = cp;
        com_wdis = ow;
        com_plus = op;
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_gate",  64'(gate),    64'd0);
        chk("rst_busy",  64'(busy),    64'd0);
        chk("rst_done",  64'(done),    64'd0);
        chk("rst_abort", 64'(abort_o), 64'd0);
        chk("rst_wdis",  64'(wdis),    64'd0);
        m_act  = 1'b0;
        m_ab   = 1'b0;
        m_hold = 0;
        @(posedge clk);
        @(negedge clk);
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        compare_all();
        rst = 1'b0;

        // Capture L=4 N-1=2.
        set_cfg(1'b1, 3'd2, 32'd4, 3'd5, 32'd9);
        repeat (5) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b0);
        repeat (24) cyc(1'b0, 1'b0);

        // Compare L=1 N-1=0, capture fields differ.
        set_cfg(1'b0, 3'd7, 32'd13, 3'd0, 32'd1);
        cyc(1'b1, 1'b0);
        repeat (4) cyc(1'b0, 1'b0);

        // Zero-length request.
        set_cfg(1'b1, 3'd3, 32'd0, 3'd1, 32'd6);
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);

        // Close during second gate of L=5 N-1=3.
        set_cfg(1'b0, 3'd1, 32'd2, 3'd3, 32'd5);
        cyc(1'b1, 1'b0);
        repeat (11) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);

        // Reopen mid-sequence with new length, then open+close in IDLE.
        set_cfg(1'b1, 3'd1, 32'd3, 3'd0, 32'd0);
        cyc(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b0);
        set_cfg(1'b1, 3'd1, 32'd7, 3'd0, 32'd0);
        cyc(1'b1, 1'b0);
        repeat (12) cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);

        // Asynchronous reset in the gap, then a fresh sequence.
        set_cfg(1'b1, 3'd1, 32'd4, 3'd0, 32'd0);
        cyc(1'b1, 1'b0);
        repeat (5) cyc(1'b0, 1'b0);
        async_reset();
        set_cfg(1'b0, 3'd0, 32'd0, 3'd1, 32'd2);
        cyc(1'b1, 1'b0);
        repeat (8) cyc(1'b0, 1'b0);

        // Maximum length: gate stays high, then abort.
        set_cfg(1'b0, 3'd0, 32'd0, 3'd2, 32'hFFFF_FFFF);
        cyc(1'b1, 1'b0);
        repeat (20) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);

        // Random traffic; settings change every cycle to exercise freezing.
        for (int i = 0; i < 2000; i++) begin
            set_cfg(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    32'($urandom_range(0, 5)), 3'($urandom_range(0, 7)),
                    32'($urandom_range(0, 5)));
            cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
